// File: rtl/alu_pipe.sv
// alu_pipe: buffered in-order integer ALU with CDB output register.
// Optional iterative shift-add multiplier is built when ALU_PIPE_MUL_EN is defined.
package alu_pipe_pkg;
    localparam logic [5:0] OP_ADD   = 6'h01;
    localparam logic [5:0] OP_ADDI  = 6'h02;
    localparam logic [5:0] OP_SUB   = 6'h03;
    localparam logic [5:0] OP_XOR   = 6'h04;
    localparam logic [5:0] OP_XORI  = 6'h05;
    localparam logic [5:0] OP_OR    = 6'h06;
    localparam logic [5:0] OP_ORI   = 6'h07;
    localparam logic [5:0] OP_AND   = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h09;
    localparam logic [5:0] OP_SLL   = 6'h0A;
    localparam logic [5:0] OP_SLLI  = 6'h0B;
    localparam logic [5:0] OP_SRL   = 6'h0C;
    localparam logic [5:0] OP_SRLI  = 6'h0D;
    localparam logic [5:0] OP_SRA   = 6'h0E;
    localparam logic [5:0] OP_SRAI  = 6'h0F;
    localparam logic [5:0] OP_SLT   = 6'h10;
    localparam logic [5:0] OP_SLTI  = 6'h11;
    localparam logic [5:0] OP_SLTU  = 6'h12;
    localparam logic [5:0] OP_SLTIU = 6'h13;
    localparam logic [5:0] OP_BEQ   = 6'h14;
    localparam logic [5:0] OP_BNE   = 6'h15;
    localparam logic [5:0] OP_BLT   = 6'h16;
    localparam logic [5:0] OP_BGE   = 6'h17;
    localparam logic [5:0] OP_BLTU  = 6'h18;
    localparam logic [5:0] OP_BGEU  = 6'h19;
    localparam logic [5:0] OP_JALR  = 6'h1A;
    localparam logic [5:0] OP_L     = 6'h1B;
    localparam logic [5:0] OP_S     = 6'h1C;
    localparam logic [5:0] OP_MUL   = 6'h3F;
endpackage

module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [5:0]               in_opcode,
    input  logic [TAG_W-1:0]         in_rob,
    input  logic [XLEN-1:0]          in_lhs,
    input  logic [XLEN-1:0]          in_rhs,
    output logic                     cdb_valid,
    output logic [TAG_W-1:0]        cdb_rob,
    output logic [XLEN-1:0]          cdb_result,
    input  logic                     cdb_grant,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int S  = $clog2(XLEN);

    logic [5:0]       r_op  [DEPTH];
    logic [TAG_W-1:0] r_tag [DEPTH];
    logic [XLEN-1:0]  r_lhs [DEPTH];
    logic [XLEN-1:0]  r_rhs [DEPTH];
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [CW-1:0]    r_cnt;

    logic             r_valid;
    logic [TAG_W-1:0] r_rob;
    logic [XLEN-1:0]  r_res;

    logic             w_full, w_empty, w_free, w_push, w_pop, w_load;
    logic             w_idle, w_head_mul, w_mul_done;
    logic [5:0]       w_op;
    logic [XLEN-1:0]  w_a, w_b, w_sum, w_alu, w_ld_res;
    logic [TAG_W-1:0] w_ld_tag;
    logic [S-1:0]     w_sh;

    assign w_full   = (r_cnt == CW'(DEPTH));
    assign w_empty  = (r_cnt == '0);
    assign w_free   = ~r_valid | cdb_grant;
    assign w_push   = in_valid & ~w_full & rdy & ~flush;
    assign w_pop    = rdy & ~flush & w_idle & ~w_empty & w_free;

    assign in_ready   = ~w_full;
    assign occupancy  = r_cnt;
    assign cdb_valid  = r_valid;
    assign cdb_rob    = r_rob;
    assign cdb_result = r_res;

    assign w_op  = r_op[r_rptr];
    assign w_a   = r_lhs[r_rptr];
    assign w_b   = r_rhs[r_rptr];
    assign w_sh  = w_b[S-1:0];
    assign w_sum = w_a + w_b;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_op[r_wptr]  <= in_opcode;
            r_tag[r_wptr] <= in_rob;
            r_lhs[r_wptr] <= in_lhs;
            r_rhs[r_wptr] <= in_rhs;
        end
    end

    // Pointers are AW bits wide, so DEPTH being a power of 2 gives the wrap for free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else if (flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push & ~w_pop)      r_cnt <= r_cnt + 1'b1;
            else if (w_pop & ~w_push) r_cnt <= r_cnt - 1'b1;
        end
    end

    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_ADD, OP_ADDI, OP_L, OP_S: w_alu = w_sum;
            OP_SUB:                      w_alu = w_a - w_b;
            OP_XOR, OP_XORI:             w_alu = w_a ^ w_b;
            OP_OR, OP_ORI:               w_alu = w_a | w_b;
            OP_AND, OP_ANDI:             w_alu = w_a & w_b;
            OP_SLL, OP_SLLI:             w_alu = w_a << w_sh;
            OP_SRL, OP_SRLI:             w_alu = w_a >> w_sh;
            OP_SRA, OP_SRAI:             w_alu = $unsigned($signed(w_a) >>> w_sh);
            OP_SLT, OP_SLTI, OP_BLT:     w_alu = XLEN'($signed(w_a) < $signed(w_b));
            OP_BGE:                      w_alu = XLEN'($signed(w_a) >= $signed(w_b));
            OP_SLTU, OP_SLTIU, OP_BLTU:  w_alu = XLEN'(w_a < w_b);
            OP_BGEU:                     w_alu = XLEN'(w_a >= w_b);
            OP_BEQ:                      w_alu = XLEN'(w_a == w_b);
            OP_BNE:                      w_alu = XLEN'(w_a != w_b);
            OP_JALR:                     w_alu = {w_sum[XLEN-1:1], 1'b0};
            default:                     w_alu = '0;
        endcase
    end

`ifdef ALU_PIPE_MUL_EN
    localparam int MW = S + 1;

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t           r_state, w_state_nxt;
    logic [MW-1:0]    r_mcnt;
    logic [XLEN-1:0]  r_mcand, r_mplier, r_acc;
    logic [TAG_W-1:0] r_mtag;
    logic             w_mul_start, w_mul_step;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_head_mul  = (w_op == OP_MUL);
    assign w_mul_start = w_pop & w_head_mul;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       r_state <= ST_IDLE;
        else if (flush) r_state <= ST_IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_mul_start) w_state_nxt = ST_BUSY;
            ST_BUSY: if (w_mul_done)  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // One partial product per rdy cycle; completion waits for a free output register.
    always_comb begin
        w_mul_step = 1'b0;
        w_mul_done = 1'b0;
        if (r_state == ST_BUSY && rdy && !flush) begin
            if (r_mcnt != MW'(XLEN)) w_mul_step = 1'b1;
            else if (w_free)         w_mul_done = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mcnt   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_mtag   <= '0;
        end else if (w_mul_start) begin
            r_mcnt   <= '0;
            r_mcand  <= w_a;
            r_mplier <= w_b;
            r_acc    <= '0;
            r_mtag   <= r_tag[r_rptr];
        end else if (w_mul_step) begin
            if (r_mplier[0]) r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_mcnt   <= r_mcnt + 1'b1;
        end
    end

    assign w_ld_res = w_mul_done ? r_acc  : w_alu;
    assign w_ld_tag = w_mul_done ? r_mtag : r_tag[r_rptr];
`else
    assign w_idle     = 1'b1;
    assign w_head_mul = 1'b0;
    assign w_mul_done = 1'b0;
    assign w_ld_res   = w_alu;
    assign w_ld_tag   = r_tag[r_rptr];
`endif

    assign w_load = (w_pop & ~w_head_mul) | w_mul_done;

    // A grant with nothing to load drops valid but keeps tag/result for inspection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_rob   <= '0;
            r_res   <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (rdy) begin
            if (w_load) begin
                r_valid <= 1'b1;
                r_rob   <= w_ld_tag;
                r_res   <= w_ld_res;
            end else if (cdb_grant) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: opcode table, directed corner sequences, random vs queue model.
`timescale 1ns/1ps
module tb_alu_pipe;
    import alu_pipe_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst, rdy, flush, in_valid, cdb_grant;
    logic             in_ready, cdb_valid;
    logic [5:0]       in_opcode;
    logic [TAG_W-1:0] in_rob, cdb_rob;
    logic [XLEN-1:0]  in_lhs, in_rhs, cdb_result;
    logic [2:0]       occupancy;

    alu_pipe #(.XLEN(XLEN), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_rob(in_rob), .in_lhs(in_lhs), .in_rhs(in_rhs),
        .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_result(cdb_result),
        .cdb_grant(cdb_grant), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] lhs;
        logic [31:0] rhs;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [31:0]      res;
    } ent_t;

    vec_t vt[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic [5:0] op, input logic [31:0] l, input logic [31:0] r,
                           input logic [31:0] e);
        vec_t v;
        v.op = op; v.lhs = l; v.rhs = r; v.exp = e;
        vt.push_back(v);
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] l,
                         input logic [31:0] r, input logic [TAG_W-1:0] t);
        in_valid = v; in_opcode = op; in_lhs = l; in_rhs = r; in_rob = t;
    endtask

    // Single op into an idle pipe: push at edge N, visible after N+1, then granted away.
    task automatic run_one(input string name, input logic [5:0] op, input logic [31:0] l,
                           input logic [31:0] r, input logic [TAG_W-1:0] t, input logic [31:0] e);
        cdb_grant = 1'b0;
        drive(1'b1, op, l, r, t);
        tick;
        drive(1'b0, 6'h00, 32'h0, 32'h0, '0);
        check({name, "_occ_after_push"}, 64'(occupancy), 64'd1);
        tick;
        check({name, "_valid"}, 64'(cdb_valid), 64'd1);
        check({name, "_rob"}, 64'(cdb_rob), 64'(t));
        check({name, "_result"}, 64'(cdb_result), 64'(e));
        cdb_grant = 1'b1;
        tick;
        cdb_grant = 1'b0;
        check({name, "_valid_after_grant"}, 64'(cdb_valid), 64'd0);
    endtask

    function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned sh;
        longint sa, sb;
        sh = b % 32;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            OP_ADD, OP_ADDI, OP_L, OP_S: return a + b;
            OP_SUB:                      return a - b;
            OP_XOR, OP_XORI:             return a ^ b;
            OP_OR, OP_ORI:               return a | b;
            OP_AND, OP_ANDI:             return a & b;
            OP_SLL, OP_SLLI:             return 32'((64'(a) * (64'd1 << sh)));
            OP_SRL, OP_SRLI:             return a / (32'd1 << sh);
            OP_SRA, OP_SRAI:             return 32'(sa >>> sh);
            OP_SLT, OP_SLTI, OP_BLT:     return (sa < sb) ? 32'd1 : 32'd0;
            OP_BGE:                      return (sa >= sb) ? 32'd1 : 32'd0;
            OP_SLTU, OP_SLTIU, OP_BLTU:  return (a < b) ? 32'd1 : 32'd0;
            OP_BGEU:                     return (a >= b) ? 32'd1 : 32'd0;
            OP_BEQ:                      return (a == b) ? 32'd1 : 32'd0;
            OP_BNE:                      return (a != b) ? 32'd1 : 32'd0;
            OP_JALR:                     return (a + b) & 32'hFFFF_FFFE;
            default:                     return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        ent_t q[$];
        ent_t e;
        logic        m_valid;
        logic [TAG_W-1:0] m_rob;
        logic [31:0] m_res;
        logic        do_pop, do_push;
        int          k, seen;

        rst = 1'b0; rdy = 1'b1; flush = 1'b0; cdb_grant = 1'b0;
        drive(1'b0, 6'h00, 32'h0, 32'h0, '0);
        tick;
        check("reset_valid", 64'(cdb_valid), 64'd0);
        check("reset_rob", 64'(cdb_rob), 64'd0);
        check("reset_result", 64'(cdb_result), 64'd0);
        check("reset_occupancy", 64'(occupancy), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b1;
        tick;

        add_vec(OP_ADD,   32'd5,          32'd7,          32'd12);
        add_vec(OP_ADDI,  32'hFFFF_FFFF,  32'd1,          32'd0);
        add_vec(OP_L,     32'h1000,       32'hFFFF_FFFC,  32'h0FFC);
        add_vec(OP_S,     32'h20,         32'h8,          32'h28);
        add_vec(OP_SUB,   32'd3,          32'd5,          32'hFFFF_FFFE);
        add_vec(OP_XOR,   32'hF0F0,       32'hFF00,       32'h0FF0);
        add_vec(OP_XORI,  32'hAAAA_5555,  32'hFFFF_FFFF,  32'h5555_AAAA);
        add_vec(OP_OR,    32'hF0,         32'h0F,         32'hFF);
        add_vec(OP_ORI,   32'h100,        32'h1,          32'h101);
        add_vec(OP_AND,   32'hF0F0,       32'hFF00,       32'hF000);
        add_vec(OP_ANDI,  32'h1234_5678,  32'hFF,         32'h78);
        add_vec(OP_SLL,   32'd1,          32'd31,         32'h8000_0000);
        add_vec(OP_SLLI,  32'd1,          32'd33,         32'd2);
        add_vec(OP_SRL,   32'h8000_0000,  32'd4,          32'h0800_0000);
        add_vec(OP_SRLI,  32'hFFFF_FFFF,  32'd36,         32'h0FFF_FFFF);
        add_vec(OP_SRA,   32'h8000_0000,  32'd4,          32'hF800_0000);
        add_vec(OP_SRAI,  32'h4000_0000,  32'd30,         32'd1);
        add_vec(OP_SLT,   32'hFFFF_FFFF,  32'd1,          32'd1);
        add_vec(OP_SLTI,  32'd1,          32'hFFFF_FFFF,  32'd0);
        add_vec(OP_SLTU,  32'd1,          32'hFFFF_FFFF,  32'd1);
        add_vec(OP_SLTIU, 32'hFFFF_FFFF,  32'd1,          32'd0);
        add_vec(OP_BEQ,   32'd5,          32'd5,          32'd1);
        add_vec(OP_BNE,   32'd5,          32'd5,          32'd0);
        add_vec(OP_BLT,   32'h8000_0000,  32'd0,          32'd1);
        add_vec(OP_BGE,   32'h8000_0000,  32'd0,          32'd0);
        add_vec(OP_BLTU,  32'h8000_0000,  32'd0,          32'd0);
        add_vec(OP_BGEU,  32'h8000_0000,  32'd0,          32'd1);
        add_vec(OP_JALR,  32'h1001,       32'd2,          32'h1002);
        add_vec(6'h00,    32'd9,          32'd9,          32'd0);
        add_vec(6'h30,    32'd9,          32'd9,          32'd0);
`ifndef ALU_PIPE_MUL_EN
        add_vec(OP_MUL,   32'hFFFF,       32'h1_0001,     32'd0);
`endif
        for (int i = 0; i < vt.size(); i++)
            run_one($sformatf("vec%0d_op%0h", i, vt[i].op), vt[i].op, vt[i].lhs, vt[i].rhs,
                    TAG_W'(i), vt[i].exp);

        // Back-to-back stream with grant held high: one result per cycle, in order.
        cdb_grant = 1'b1;
        drive(1'b1, OP_SRA, 32'h8000_0000, 32'd4, 4'd1);
        tick;
        drive(1'b1, OP_SLTU, 32'd1, 32'hFFFF_FFFF, 4'd2);
        tick;
        check("stream0_result", 64'(cdb_result), 64'hF800_0000);
        check("stream0_rob", 64'(cdb_rob), 64'd1);
        drive(1'b1, OP_JALR, 32'h1001, 32'd2, 4'd3);
        tick;
        check("stream1_result", 64'(cdb_result), 64'd1);
        drive(1'b0, 6'h00, 32'h0, 32'h0, '0);
        tick;
        check("stream2_result", 64'(cdb_result), 64'h1002);
        check("stream2_valid", 64'(cdb_valid), 64'd1);
        tick;
        check("stream_drain_valid", 64'(cdb_valid), 64'd0);

        // Held result with a filling queue: 1 in the output register + DEPTH queued.
        cdb_grant = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, OP_ADD, 32'(i * 16), 32'd1, TAG_W'(8 + i));
            tick;
        end
        check("full_occupancy", 64'(occupancy), 64'd4);
        check("full_in_ready", 64'(in_ready), 64'd0);
        drive(1'b1, OP_ADD, 32'd80, 32'd1, 4'd13);
        for (int i = 0; i < 3; i++) begin
            tick;
            check("blocked_occupancy", 64'(occupancy), 64'd4);
            check("held_result", 64'(cdb_result), 64'd1);
            check("held_rob", 64'(cdb_rob), 64'd8);
        end
        cdb_grant = 1'b1;
        tick;
        cdb_grant = 1'b0;
        check("after_grant_result", 64'(cdb_result), 64'd17);
        check("after_grant_in_ready", 64'(in_ready), 64'd1);
        check("after_grant_occupancy", 64'(occupancy), 64'd3);
        tick;
        check("fifth_push_occupancy", 64'(occupancy), 64'd4);
        flush = 1'b1;
        drive(1'b1, OP_ADD, 32'd99, 32'd1, 4'd14);
        tick;
        flush = 1'b0;
        drive(1'b0, 6'h00, 32'h0, 32'h0, '0);
        check("flush_occupancy", 64'(occupancy), 64'd0);
        check("flush_valid", 64'(cdb_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        run_one("post_flush_add", OP_ADD, 32'd1, 32'd1, 4'd5, 32'd2);

        // rdy low mid-stream: grant and valid input are both ignored.
        cdb_grant = 1'b1;
        drive(1'b1, OP_ADD, 32'd100, 32'd1, 4'd1);
        tick;
        drive(1'b1, OP_SUB, 32'd50, 32'd8, 4'd2);
        tick;
        drive(1'b1, OP_XOR, 32'hFF, 32'h0F, 4'd3);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("stall_valid", 64'(cdb_valid), 64'd1);
            check("stall_result", 64'(cdb_result), 64'd101);
            check("stall_rob", 64'(cdb_rob), 64'd1);
            check("stall_occupancy", 64'(occupancy), 64'd1);
        end
        rdy = 1'b1;
        tick;
        drive(1'b0, 6'h00, 32'h0, 32'h0, '0);
        check("resume0_result", 64'(cdb_result), 64'd42);
        check("resume0_rob", 64'(cdb_rob), 64'd2);
        tick;
        check("resume1_result", 64'(cdb_result), 64'hF0);
        tick;
        check("resume_drain_valid", 64'(cdb_valid), 64'd0);
        cdb_grant = 1'b0;

`ifdef ALU_PIPE_MUL_EN
        drive(1'b1, OP_MUL, 32'hFFFF, 32'h1_0001, 4'd7);
        tick;
        drive(1'b0, 6'h00, 32'h0, 32'h0, '0);
        tick;
        check("mul_pop_occupancy", 64'(occupancy), 64'd0);
        k = 0;
        for (int i = 1; i <= 100; i++) begin
            tick;
            if (cdb_valid) begin k = i; break; end
        end
        check("mul_latency", 64'(k), 64'd33);
        check("mul_result", 64'(cdb_result), 64'hFFFF_FFFF);
        check("mul_rob", 64'(cdb_rob), 64'd7);
        cdb_grant = 1'b1;
        tick;
        cdb_grant = 1'b0;
        drive(1'b1, OP_MUL, 32'hFFFF, 32'h1_0001, 4'd6);
        tick;
        drive(1'b0, 6'h00, 32'h0, 32'h0, '0);
        tick;
        for (int i = 0; i < 9; i++) tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (cdb_valid) seen++;
        end
        check("mul_flush_no_result", 64'(seen), 64'd0);
        run_one("post_mul_flush_add", OP_ADD, 32'd3, 32'd4, 4'd9, 32'd7);
`endif

        // Random traffic against a queue-level model of the pipeline.
        flush = 1'b1;
        tick;
        flush = 1'b0;
        q.delete();
        m_valid = 1'b0; m_rob = '0; m_res = '0;
        for (int c = 0; c < 800; c++) begin
            rdy       = ($urandom_range(0, 9) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            cdb_grant = $urandom_range(0, 1) != 0;
            drive($urandom_range(0, 9) < 6, 6'($urandom_range(0, 31)), rnd_operand(),
                  rnd_operand(), TAG_W'($urandom));
            check("rnd_in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
            check("rnd_occupancy", 64'(occupancy), 64'(q.size()));
            check("rnd_valid", 64'(cdb_valid), 64'(m_valid));
            if (m_valid) begin
                check("rnd_rob", 64'(cdb_rob), 64'(m_rob));
                check("rnd_result", 64'(cdb_result), 64'(m_res));
            end
            if (flush) begin
                q.delete();
                m_valid = 1'b0;
            end else if (rdy) begin
                do_push = in_valid && (q.size() < DEPTH);
                do_pop  = (q.size() > 0) && (!m_valid || cdb_grant);
                if (do_pop) begin
                    e = q.pop_front();
                    m_valid = 1'b1; m_rob = e.tag; m_res = e.res;
                end else if (cdb_grant) begin
                    m_valid = 1'b0;
                end
                if (do_push) begin
                    e.tag = in_rob;
                    e.res = ref_alu(in_opcode, in_lhs, in_rhs);
                    q.push_back(e);
                end
            end
            tick;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
